// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-byte holding register, valid/ready handoff
module uart_rx #(
  parameter int CLK_HZ = 9 * 115200,
  parameter int BAUD   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

  // A receiver with fewer than four clocks per bit cannot centre its samples.
  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    S_WAITH = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [1:0]      r_warm;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;

  logic            w_tick;
  logic            w_start_det;
  logic            w_shift;
  logic            w_good;
  logic            w_bad;
  logic            w_take;
  logic            w_load;
  logic            w_ovr;

  // Two-flop synchronizer; r_warm marks when r_rx_s reflects the real line after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_warm    <= 2'b00;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_warm    <= {r_warm[0], 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_WAITH;
    else       r_state <= w_next;
  end

  // FSM next-state logic; every bit-level decision happens on a counter tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAITH: if (r_rx_s && r_warm[1]) w_next = S_IDLE;
      S_IDLE:  if (!r_rx_s)             w_next = S_START;
      S_START: if (w_tick)              w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && r_bit == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_tick)              w_next = r_rx_s ? S_IDLE : S_WAITH;
      default:                          w_next = S_WAITH;
    endcase
  end

  // FSM outputs: strobes that steer the datapath registers.
  always_comb begin
    w_tick      = (r_cnt == '0);
    w_start_det = (r_state == S_IDLE) && !r_rx_s;
    w_shift     = (r_state == S_DATA) && w_tick;
    w_good      = (r_state == S_STOP) && w_tick && r_rx_s;
    w_bad       = (r_state == S_STOP) && w_tick && !r_rx_s;
    w_take      = r_valid && i_ready;
    w_load      = w_good && (!r_valid || w_take);
    w_ovr       = w_good && !w_load;
  end

  // Bit timer: half period to reach mid start bit, then full periods between samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_start_det) begin
      r_cnt <= HALF_LD;
    end else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
      r_cnt <= w_tick ? FULL_LD : r_cnt - 1'b1;
    end
  end

  // Bit index and LSB-first shift register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (r_state == S_START && w_tick) r_bit <= 3'd0;
      else if (w_shift)                 r_bit <= r_bit + 3'd1;
      if (w_shift) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  // Holding register and status flags; a load on a consuming edge keeps valid high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      if (w_load) r_data <= r_shift;
      if (w_load)      r_valid <= 1'b1;
      else if (w_take) r_valid <= 1'b0;
      if (w_ovr)       r_overrun <= 1'b1;
      else if (w_take) r_overrun <= 1'b0;
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 9 clocks per bit
module tb_uart_rx;

  logic       i_clk;
  logic       i_rst;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;

  logic       r_rd;
  logic       auto_rd;
  int         cyc;
  int         e_cyc;
  int         rise_cyc;
  int         rise_cnt;
  int         ferr_cyc;
  int         ferr_cnt;
  logic       prev_valid;
  logic [7:0] got[$];
  int         checks;
  int         failures;
  int         base_rise;
  int         base_ferr;

  uart_rx #(.CLK_HZ(9 * 115200), .BAUD(115200)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  assign i_ready = r_rd | auto_rd;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    prev_valid <= o_valid;
    if (o_valid && !prev_valid) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (o_frame_err) begin
      ferr_cyc <= cyc;
      ferr_cnt <= ferr_cnt + 1;
    end
    if (auto_rd && o_valid) got.push_back(o_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame, 9 clocks per bit; caller is #1 after a rising edge.
  // rd_stop raises ready for exactly the stop-sample edge; rst_idx pulses reset inside that frame bit.
  task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit rd_stop, input int rst_idx);
    logic [9:0] fr;
    bit ab;
    fr = {good_stop, b, 1'b0};
    ab = 1'b0;
    e_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      i_rx = ab ? 1'b1 : fr[i];
      for (int j = 0; j < 9; j++) begin
        @(posedge i_clk);
        #1;
        if (rd_stop && i == 9 && j == 5) r_rd = 1'b1;
        if (rd_stop && i == 9 && j == 6) r_rd = 1'b0;
        if (i == rst_idx && j == 3) i_rst = 1'b1;
        if (i == rst_idx && j == 4) begin
          i_rst = 1'b0;
          ab    = 1'b1;
          i_rx  = 1'b1;
        end
      end
    end
  endtask

  task automatic read_pulse();
    r_rd = 1'b1;
    tick(1);
    r_rd = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rise_cnt = 0; ferr_cnt = 0; rise_cyc = 0; ferr_cyc = 0; prev_valid = 1'b0;
    r_rd = 1'b0; auto_rd = 1'b0; i_rx = 1'b1; i_rst = 1'b1;
    tick(3);
    i_rst = 1'b0;
    tick(1);
    check("reset_data", o_data, 8'h00);
    check("reset_valid", o_valid, 1'b0);
    check("reset_frame_err", o_frame_err, 1'b0);
    check("reset_overrun", o_overrun, 1'b0);
    tick(10);

    // Single byte and the stop-edge latency
    send_byte(8'hA5, 1'b1, 1'b0, -1);
    check("single_rise_edge", rise_cyc, e_cyc + 87);
    check("single_data", o_data, 8'hA5);
    check("single_valid", o_valid, 1'b1);
    check("single_ferr", ferr_cnt, 0);
    check("single_overrun", o_overrun, 1'b0);
    read_pulse();
    check("single_valid_drop", o_valid, 1'b0);
    tick(5);

    // Back-to-back frames with an immediate reader
    auto_rd = 1'b1;
    send_byte(8'h00, 1'b1, 1'b0, -1);
    send_byte(8'hFF, 1'b1, 1'b0, -1);
    send_byte(8'h55, 1'b1, 1'b0, -1);
    tick(4);
    auto_rd = 1'b0;
    check("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      check("b2b_byte0", got[0], 8'h00);
      check("b2b_byte1", got[1], 8'hFF);
      check("b2b_byte2", got[2], 8'h55);
    end
    check("b2b_overrun", o_overrun, 1'b0);
    check("b2b_ferr", ferr_cnt, 0);
    check("b2b_valid", o_valid, 1'b0);
    tick(5);

    // Overrun: second byte arrives while first is unread
    send_byte(8'h11, 1'b1, 1'b0, -1);
    send_byte(8'h22, 1'b1, 1'b0, -1);
    check("ovr_data", o_data, 8'h11);
    check("ovr_valid", o_valid, 1'b1);
    check("ovr_flag", o_overrun, 1'b1);
    read_pulse();
    check("ovr_read_valid", o_valid, 1'b0);
    check("ovr_read_flag", o_overrun, 1'b0);
    tick(5);

    // Simultaneous read on the stop edge of the second frame
    send_byte(8'h11, 1'b1, 1'b0, -1);
    send_byte(8'h22, 1'b1, 1'b1, -1);
    check("simul_data", o_data, 8'h22);
    check("simul_valid", o_valid, 1'b1);
    check("simul_overrun", o_overrun, 1'b0);
    read_pulse();
    check("simul_drain", o_valid, 1'b0);
    tick(5);

    // Short glitch is rejected at the start-bit check
    base_rise = rise_cnt;
    base_ferr = ferr_cnt;
    i_rx = 1'b0;
    tick(2);
    i_rx = 1'b1;
    tick(20);
    check("glitch_no_valid", rise_cnt, base_rise);
    check("glitch_no_ferr", ferr_cnt, base_ferr);

    // Framing error followed by a break, then a good frame
    send_byte(8'h3C, 1'b0, 1'b0, -1);
    tick(30);
    i_rx = 1'b1;
    tick(10);
    check("ferr_count", ferr_cnt, base_ferr + 1);
    check("ferr_edge", ferr_cyc, e_cyc + 87);
    check("ferr_no_valid", rise_cnt, base_rise);
    send_byte(8'h3C, 1'b1, 1'b0, -1);
    check("after_ferr_data", o_data, 8'h3C);
    check("after_ferr_valid", o_valid, 1'b1);
    check("after_ferr_ferr", ferr_cnt, base_ferr + 1);
    read_pulse();
    tick(5);

    // Reset during data bit 4 (frame index 5) aborts the frame
    base_rise = rise_cnt;
    base_ferr = ferr_cnt;
    send_byte(8'hE7, 1'b1, 1'b0, 5);
    tick(10);
    check("rstmid_no_valid", rise_cnt, base_rise);
    check("rstmid_data", o_data, 8'h00);
    check("rstmid_valid", o_valid, 1'b0);
    check("rstmid_overrun", o_overrun, 1'b0);
    check("rstmid_ferr", ferr_cnt, base_ferr);
    send_byte(8'h96, 1'b1, 1'b0, -1);
    check("rstmid_next_edge", rise_cyc, e_cyc + 87);
    check("rstmid_next_data", o_data, 8'h96);
    check("rstmid_next_valid", o_valid, 1'b1);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
